// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: latency-modelled multiplier
// plus iterative restoring divider. Optional abort port enabled by MULDIV_CANCEL_EN.
module muldiv_unit #(
  parameter int MUL_LAT = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic               sgn_q;
  logic [WIDTH-1:0]   a_q, b_q, rem, quo, dvs;
  logic               kill, accept, in_signed, mul_last, div_last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] ax, bx, product;
  logic               q_neg, r_neg, div_zero;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MULDIV_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  assign accept    = (state == IDLE) && start && !kill;
  assign in_signed = ~op[0];
  assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;
  assign mul_last  = (cnt == CW'(MUL_LAT - 1));
  assign div_last  = (cnt == CW'(WIDTH - 1));

  // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign ax      = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign bx      = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = ax * bx;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    q_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg    = sgn_q & a_q[WIDTH-1];
    div_zero = (b_q == '0);
    fix_lo   = div_zero ? '1  : (q_neg ? -quo : quo);
    fix_hi   = div_zero ? a_q : (r_neg ? -rem : rem);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = op[1] ? DIV : MUL;
      MUL:  if (mul_last) next_state = IDLE;
      DIV:  if (div_last) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (state != IDLE && kill) next_state = IDLE;
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (accept) begin
            sgn_q <= in_signed;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
          end
        end
        MUL: if (!kill) begin
          if (mul_last) begin
            {hi, lo} <= product;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: if (!kill) begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: if (!kill) begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
